// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register and its per-bit cells.
// Mode codes are fixed by the sel port: hold, shift left, shift right, parallel load.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'b00;
  localparam logic [1:0] USR_SHL  = 2'b01;
  localparam logic [1:0] USR_SHR  = 2'b10;
  localparam logic [1:0] USR_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ModeHold = USR_HOLD,
    ModeShl  = USR_SHL,
    ModeShr  = USR_SHR,
    ModeLoad = USR_LOAD
  } usr_mode_e;

  // Maps a raw select value onto the mode type; all four codes are legal.
  function automatic usr_mode_e usr_decode(input logic [1:0] sel);
    return usr_mode_e'(sel);
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: a 4:1 next-state mux feeding a flop.
// i_from_lo is the neighbour taken on a left shift, i_from_hi the one taken on a right shift.
module usr_bit_cell
  import usr_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  usr_mode_e i_mode,
  input  logic      i_from_lo,
  input  logic      i_from_hi,
  input  logic      i_load,
  output logic      o_q
);

  logic r_q;
  logic w_d;

  always_comb begin
    w_d = r_q;
    unique case (i_mode)
      ModeHold: w_d = r_q;
      ModeShl:  w_d = i_from_lo;
      ModeShr:  w_d = i_from_hi;
      ModeLoad: w_d = i_load;
      default:  w_d = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_register.sv
// Parameterised universal shift register: hold, shift left, shift right, parallel load.
// Optional macro USR_ROTATE_EN adds a rot input that turns the shift modes into rotates.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  output logic [WIDTH-1:0] PO,
  input  logic [WIDTH-1:0] PI,
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       sel,
  input  logic             SI
`ifdef USR_ROTATE_EN
  ,
  input  logic             rot
`endif
);

  usr_mode_e        w_mode;
  logic             w_lsb_fill;
  logic             w_msb_fill;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_from_lo;
  logic [WIDTH-1:0] w_from_hi;

  assign w_mode = usr_decode(sel);

`ifdef USR_ROTATE_EN
  // While rotating, the boundary bits wrap around and SI is ignored.
  assign w_lsb_fill = rot ? w_q[WIDTH-1] : SI;
  assign w_msb_fill = rot ? w_q[0]       : SI;
`else
  assign w_lsb_fill = SI;
  assign w_msb_fill = SI;
`endif

  assign w_from_lo = {w_q[WIDTH-2:0], w_lsb_fill};
  assign w_from_hi = {w_msb_fill, w_q[WIDTH-1:1]};

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    usr_bit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .i_mode    (w_mode),
      .i_from_lo (w_from_lo[g]),
      .i_from_hi (w_from_hi[g]),
      .i_load    (PI[g]),
      .o_q       (w_q[g])
    );
  end

  assign PO = w_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed self-checking bench for universal_shift_register (WIDTH=4).
// Rotate steps are included when USR_ROTATE_EN is defined.
module tb_universal_shift_register;

  localparam int unsigned W = 4;

  logic [W-1:0] PO;
  logic [W-1:0] PI;
  logic         clk;
  logic         rst;
  logic [1:0]   sel;
  logic         SI;
  logic         rot;

  int n_checks;
  int n_fails;

  universal_shift_register #(
    .WIDTH (W)
  ) dut (
    .PO  (PO),
    .PI  (PI),
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .SI  (SI)
`ifdef USR_ROTATE_EN
    ,
    .rot (rot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [1:0] s, input logic [W-1:0] p,
                      input logic si, input logic ro);
    @(negedge clk);
    rst = r;
    sel = s;
    PI  = p;
    SI  = si;
    rot = ro;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] exp);
    n_checks++;
    assert (PO === exp)
    else begin
      n_fails++;
      $error("FAIL %s: PO=%b expected %b", tag, PO, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    sel = 2'b00;
    PI  = '0;
    SI  = 1'b0;
    rot = 1'b0;

    step(1'b1, 2'b00, 4'b0000, 1'b0, 1'b0);
    check("reset", 4'b0000);

    step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
    check("load_1010", 4'b1010);

    step(1'b0, 2'b00, 4'b0110, 1'b1, 1'b0);
    check("hold", 4'b1010);

    step(1'b0, 2'b01, 4'b0110, 1'b1, 1'b0);
    check("shl_si1", 4'b0101);

    step(1'b0, 2'b10, 4'b0110, 1'b0, 1'b0);
    check("shr_1", 4'b0010);
    step(1'b0, 2'b10, 4'b0110, 1'b0, 1'b0);
    check("shr_2", 4'b0001);
    step(1'b0, 2'b10, 4'b0110, 1'b0, 1'b0);
    check("shr_3", 4'b0000);
    step(1'b0, 2'b10, 4'b0110, 1'b1, 1'b0);
    check("shr_si1", 4'b1000);

    step(1'b0, 2'b11, 4'b1010, 1'b0, 1'b0);
    check("reload_1010", 4'b1010);

    // Inputs changed between edges must not disturb PO.
    @(negedge clk);
    sel = 2'b11;
    PI  = 4'b0101;
    #2;
    check("stable_between_edges", 4'b1010);

    step(1'b1, 2'b11, 4'b1111, 1'b1, 1'b0);
    check("reset_priority", 4'b0000);
    step(1'b0, 2'b11, 4'b1111, 1'b1, 1'b0);
    check("resume_load", 4'b1111);

    step(1'b0, 2'b01, 4'b0000, 1'b0, 1'b0);
    check("shl_si0", 4'b1110);
    step(1'b0, 2'b10, 4'b0000, 1'b1, 1'b0);
    check("shr_si1_b", 4'b1111);
    step(1'b0, 2'b00, 4'b0000, 1'b0, 1'b0);
    check("hold_b", 4'b1111);
    step(1'b1, 2'b01, 4'b0000, 1'b1, 1'b0);
    check("reset_over_shl", 4'b0000);

`ifdef USR_ROTATE_EN
    step(1'b0, 2'b11, 4'b1001, 1'b0, 1'b0);
    check("rot_load", 4'b1001);
    step(1'b0, 2'b01, 4'b1001, 1'b0, 1'b1);
    check("rotl", 4'b0011);
    step(1'b0, 2'b10, 4'b1001, 1'b0, 1'b1);
    check("rotr", 4'b1001);
    step(1'b0, 2'b11, 4'b0110, 1'b0, 1'b1);
    check("rot_no_effect_load", 4'b0110);
    step(1'b1, 2'b01, 4'b0110, 1'b0, 1'b1);
    check("rot_reset_priority", 4'b0000);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
